// File: rtl/xps2_rx_fifo_if.sv
// PS/2 receiver bus bundle: raw PS/2 pins in, controller read port out.
// master = pin/controller side (drives pins and sel), slave = receiver.
interface xps2_rx_fifo_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic       sel;
  logic [8:0] data_out;
  logic       frame_err;
  logic       overflow;

  modport master (
    output ps2_clk, ps2_data, sel,
    input  data_out, frame_err, overflow
  );

  modport slave (
    input  ps2_clk, ps2_data, sel,
    output data_out, frame_err, overflow
  );
endinterface

// File: rtl/xps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronises the pins, deserialises 11-bit frames
// (start, 8 data LSB first, odd parity, stop), drops bad or stalled frames,
// and queues good scan codes in a small FIFO read as {valid, code}.
module xps2_rx_fifo #(
  parameter int FIFO_AW        = 3,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input logic           clk,
  input logic           rst,     // active-low async reset
  xps2_rx_fifo_if.slave bus
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // input conditioning
  logic [SYNC_STAGES-1:0] r_sclk, r_sdat;
  logic                   r_prev_clk;
  logic                   w_sclk, w_sdat, w_fall;

  // frame FSM
  state_t          r_state, w_state_nxt;
  logic [7:0]      r_shreg, w_shreg_nxt;
  logic [2:0]      r_bitcnt, w_bitcnt_nxt;
  logic            r_par_ok, w_par_ok_nxt;
  logic [WD_W-1:0] r_wdog, w_wdog_nxt;
  logic            w_push, w_err;
  logic            r_frame_err;

  // FIFO
  logic [7:0]       r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [FIFO_AW:0]   r_cnt;
  logic             r_overflow;
  logic             w_empty, w_full, w_pop, w_wr, w_ovf;

  assign w_sclk = r_sclk[SYNC_STAGES-1];
  assign w_sdat = r_sdat[SYNC_STAGES-1];
  assign w_fall = r_prev_clk & ~w_sclk;

  // Synchroniser chains and falling-edge history; idle-high pins reset to 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sclk     <= '1;
      r_sdat     <= '1;
      r_prev_clk <= 1'b1;
    end else begin
      r_sclk     <= {r_sclk[SYNC_STAGES-2:0], bus.ps2_clk};
      r_sdat     <= {r_sdat[SYNC_STAGES-2:0], bus.ps2_data};
      r_prev_clk <= w_sclk;
    end
  end

  // Frame FSM state, datapath registers and registered error pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_shreg     <= '0;
      r_bitcnt    <= '0;
      r_par_ok    <= 1'b0;
      r_wdog      <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shreg     <= w_shreg_nxt;
      r_bitcnt    <= w_bitcnt_nxt;
      r_par_ok    <= w_par_ok_nxt;
      r_wdog      <= w_wdog_nxt;
      r_frame_err <= w_err;
    end
  end

  // Next-state logic: bit sampling on each PS/2 falling edge, watchdog otherwise.
  always_comb begin
    w_state_nxt  = r_state;
    w_shreg_nxt  = r_shreg;
    w_bitcnt_nxt = r_bitcnt;
    w_par_ok_nxt = r_par_ok;
    w_wdog_nxt   = '0;
    w_push       = 1'b0;
    w_err        = 1'b0;

    // watchdog only runs inside a frame; every fall restarts it
    if (r_state != S_IDLE && !w_fall)
      w_wdog_nxt = r_wdog + WD_W'(1);

    if (r_state != S_IDLE && !w_fall && r_wdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
      w_state_nxt = S_IDLE;
      w_err       = 1'b1;
      w_wdog_nxt  = '0;
    end else if (w_fall) begin
      case (r_state)
        S_IDLE: if (!w_sdat) begin
          w_state_nxt  = S_DATA;
          w_bitcnt_nxt = '0;
        end
        S_DATA: begin
          w_shreg_nxt  = {w_sdat, r_shreg[7:1]};
          w_bitcnt_nxt = r_bitcnt + 3'd1;
          if (r_bitcnt == 3'd7) w_state_nxt = S_PARITY;
        end
        S_PARITY: begin
          w_par_ok_nxt = ^{r_shreg, w_sdat};
          w_state_nxt  = S_STOP;
        end
        S_STOP: begin
          if (w_sdat && r_par_ok) w_push = 1'b1;
          else                    w_err  = 1'b1;
          w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == (FIFO_AW+1)'(DEPTH));
  assign w_pop   = bus.sel & ~w_empty;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign w_wr    = w_push & (~w_full | w_pop);
  assign w_ovf   = w_push & w_full & ~w_pop;

  // FIFO storage; contents are only visible through the valid count.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_shreg;
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_cnt <= r_cnt + (FIFO_AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (FIFO_AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (w_ovf) r_overflow <= 1'b1;
    end
  end

  assign bus.data_out  = w_empty ? 9'h000 : {1'b1, r_mem[r_rd_ptr]};
  assign bus.frame_err = r_frame_err;
  assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_xps2_rx_fifo.sv
// Self-checking bench for xps2_rx_fifo: table of single frames, directed
// corner sequences, then random frames against a queue-based model.
module tb_xps2_rx_fifo;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   ferr_cnt = 0;

  xps2_rx_fifo_if bus();

  xps2_rx_fifo #(.FIFO_AW(3), .SYNC_STAGES(2), .TIMEOUT_CYCLES(200)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // count frame_err pulses, sampled away from the active edge
  always @(negedge clk) if (bus.frame_err === 1'b1) ferr_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] code;
    bit         par_flip;
    bit         stop;
    logic [8:0] exp_data;
    int         exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] mk_bits(input logic [7:0] code, input bit par_flip, input bit stop);
    logic par;
    par = ~(^code) ^ par_flip;        // odd parity over code+par
    return {stop, par, code, 1'b0};
  endfunction

  // Drive n bits of a frame, bit 0 first; 40-cycle PS/2 clock period.
  // With sel_stop, sel is raised in the cycle the stop-bit push lands.
  task automatic send_bits(input logic [10:0] bits, input int n, input bit sel_stop,
                           output logic [8:0] seen);
    seen = 'x;
    for (int i = 0; i < n; i++) begin
      bus.ps2_data = bits[i];
      repeat (20) @(negedge clk);
      bus.ps2_clk = 1'b0;
      if (sel_stop && i == 10) begin
        repeat (2) @(negedge clk);
        seen = bus.data_out;
        bus.sel = 1'b1;
        @(negedge clk);
        bus.sel = 1'b0;
        repeat (17) @(negedge clk);
      end else begin
        repeat (20) @(negedge clk);
      end
      bus.ps2_clk = 1'b1;
    end
    bus.ps2_data = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] code, input bit par_flip, input bit stop);
    logic [8:0] dummy;
    send_bits(mk_bits(code, par_flip, stop), 11, 1'b0, dummy);
  endtask

  task automatic pop_chk(input string name, input logic [8:0] exp);
    chk(name, 32'(bus.data_out), 32'(exp));
    bus.sel = 1'b1;
    @(negedge clk);
    bus.sel = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  vec_t       vecs[7];
  logic [7:0] q[$];
  bit         m_ovf;

  initial begin
    int         e0, tcyc;
    bit         seen_err;
    logic [8:0] seen;
    logic [10:0] bits;

    vecs[0] = '{8'h1C, 1'b0, 1'b1, 9'h11C, 0};
    vecs[1] = '{8'h1C, 1'b1, 1'b1, 9'h000, 1};
    vecs[2] = '{8'hA5, 1'b0, 1'b1, 9'h1A5, 0};
    vecs[3] = '{8'hA5, 1'b0, 1'b0, 9'h000, 1};
    vecs[4] = '{8'h00, 1'b0, 1'b1, 9'h100, 0};
    vecs[5] = '{8'hFF, 1'b0, 1'b1, 9'h1FF, 0};
    vecs[6] = '{8'hFF, 1'b1, 1'b0, 9'h000, 1};

    rst = 1'b0;
    bus.ps2_clk = 1'b1; bus.ps2_data = 1'b1; bus.sel = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset data_out", 32'(bus.data_out), 32'h000);
    chk("reset frame_err", 32'(bus.frame_err), 32'h0);
    chk("reset overflow", 32'(bus.overflow), 32'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // single frames from an empty FIFO
    for (int i = 0; i < 7; i++) begin
      e0 = ferr_cnt;
      send_frame(vecs[i].code, vecs[i].par_flip, vecs[i].stop);
      chk($sformatf("vec%0d data_out", i), 32'(bus.data_out), 32'(vecs[i].exp_data));
      chk($sformatf("vec%0d frame_err", i), 32'(ferr_cnt - e0), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d overflow", i), 32'(bus.overflow), 32'h0);
      if (vecs[i].exp_data[8]) pop_chk($sformatf("vec%0d pop", i), vecs[i].exp_data);
      chk($sformatf("vec%0d empty", i), 32'(bus.data_out), 32'h000);
    end

    // nine frames, no reads: ninth is dropped
    for (int i = 1; i <= 9; i++) begin
      send_frame(8'(i), 1'b0, 1'b1);
      if (i == 8) chk("ovf after 8", 32'(bus.overflow), 32'h0);
    end
    chk("ovf after 9", 32'(bus.overflow), 32'h1);
    for (int i = 1; i <= 9; i++)
      pop_chk($sformatf("drain%0d", i), (i <= 8) ? {1'b1, 8'(i)} : 9'h000);
    chk("drain empty", 32'(bus.data_out), 32'h000);

    // stalled frame: timeout about 200 cycles after last fall
    e0 = ferr_cnt;
    bits = mk_bits(8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      bus.ps2_data = bits[i];
      repeat (20) @(negedge clk);
      bus.ps2_clk = 1'b0;
      if (i < 3) begin
        repeat (20) @(negedge clk);
        bus.ps2_clk = 1'b1;
      end
    end
    @(negedge clk);
    bus.ps2_clk = 1'b1;
    bus.ps2_data = 1'b1;
    tcyc = 1; seen_err = 1'b0;
    while (!seen_err && tcyc < 400) begin
      @(negedge clk); tcyc++;
      if (ferr_cnt != e0) seen_err = 1'b1;
    end
    chk("timeout seen", 32'(seen_err), 32'h1);
    chk("timeout window", 32'(tcyc >= 195 && tcyc <= 215), 32'h1);
    repeat (20) @(negedge clk);
    chk("timeout one pulse", 32'(ferr_cnt - e0), 32'h1);
    chk("timeout no data", 32'(bus.data_out), 32'h000);
    send_frame(8'hF0, 1'b0, 1'b1);
    chk("after timeout", 32'(bus.data_out), 32'h1F0);
    pop_chk("pop F0", 9'h1F0);

    // full FIFO, pop in the same cycle as a push
    do_reset();
    for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b1);
    send_bits(mk_bits(8'h18, 1'b0, 1'b1), 11, 1'b1, seen);
    chk("push+pop full read", 32'(seen), 32'h110);
    chk("push+pop full ovf", 32'(bus.overflow), 32'h0);
    for (int i = 1; i <= 8; i++) pop_chk($sformatf("full drain%0d", i), {1'b1, 8'h10 + 8'(i)});
    chk("full drain empty", 32'(bus.data_out), 32'h000);

    // reset mid-frame with data queued and overflow set
    for (int i = 0; i < 9; i++) send_frame(8'h33, 1'b0, 1'b1);
    chk("pre-reset ovf", 32'(bus.overflow), 32'h1);
    e0 = ferr_cnt;
    bits = mk_bits(8'h5A, 1'b0, 1'b1);
    send_bits(bits, 6, 1'b0, seen);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("midreset data_out", 32'(bus.data_out), 32'h000);
    chk("midreset overflow", 32'(bus.overflow), 32'h0);
    chk("midreset frame_err", 32'(bus.frame_err), 32'h0);
    rst = 1'b1;
    repeat (50) @(negedge clk);
    chk("midreset no err", 32'(ferr_cnt - e0), 32'h0);
    send_frame(8'h5A, 1'b0, 1'b1);
    chk("after reset frame", 32'(bus.data_out), 32'h15A);
    pop_chk("pop 5A", 9'h15A);

    // random frames and reads against a queue model
    m_ovf = 1'b0;
    for (int it = 0; it < 30; it++) begin
      logic [7:0] c;
      bit pf, st;
      int npop;
      c  = 8'($urandom);
      pf = ($urandom_range(0, 5) == 0);
      st = ($urandom_range(0, 5) != 0);
      e0 = ferr_cnt;
      send_frame(c, pf, st);
      if (!pf && st) begin
        if (q.size() < 8) q.push_back(c);
        else m_ovf = 1'b1;
      end
      chk($sformatf("rnd%0d err", it), 32'(ferr_cnt - e0), 32'((pf || !st) ? 1 : 0));
      chk($sformatf("rnd%0d ovf", it), 32'(bus.overflow), 32'(m_ovf));
      npop = $urandom_range(0, 2);
      for (int k = 0; k < npop; k++) begin
        if (q.size() > 0) pop_chk($sformatf("rnd%0d pop", it), {1'b1, q.pop_front()});
        else pop_chk($sformatf("rnd%0d pop empty", it), 9'h000);
      end
    end
    while (q.size() > 0) pop_chk("rnd final", {1'b1, q.pop_front()});
    chk("rnd final empty", 32'(bus.data_out), 32'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
